// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/DM arbiter for one shared fixed-latency single-ported memory
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_m,
  output logic              busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              own_dm_q, own_dm_d;
  logic              own_we_q, own_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_wins;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    own_dm_d    = own_dm_q;
    own_we_d    = own_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    dm_wins     = dm_req && (!if_req || (starve_q < 4'(STARVE_MAX)));
    case (state_q)
      IDLE: begin
        // rst gates the combinational issue path so every output reads 0 in reset
        if (rst && (if_req || dm_req)) begin
          mem_en  = 1'b1;
          state_d = WAIT;
          cnt_d   = 3'(MEM_LAT - 1);
          if (dm_wins) begin
            dm_gnt    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            addr_d    = dm_addr;
            wdata_d   = dm_wdata;
            own_dm_d  = 1'b1;
            own_we_d  = dm_we;
            if (if_req && (starve_q < 4'(STARVE_MAX))) starve_d = starve_q + 4'd1;
          end else begin
            if_gnt   = 1'b1;
            mem_addr = if_addr;
            addr_d   = if_addr;
            own_dm_d = 1'b0;
            own_we_d = 1'b0;
            starve_d = 4'd0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          if (own_dm_q) begin
            dm_rvalid_d = 1'b1;
            if (!own_we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      own_dm_q    <= 1'b0;
      own_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      own_dm_q    <= own_dm_d;
      own_we_q    <= own_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q == WAIT);
  assign stall_if  = rst & if_req & ~if_rvalid_q;
  assign stall_m   = rst & dm_req & ~dm_rvalid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  localparam int AW = 8, DW = 32, LAT = 2, SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
  logic          stall_if, stall_m, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_m(stall_m), .busy(busy)
  );

  logic [DW-1:0] mem [256];
  logic [DW-1:0] mmem [256];
  logic [DW-1:0] pipe [1:LAT];
  int errors = 0, checks = 0, cyc = 0;

  // reference model: one outstanding transaction, known issue and response cycles
  bit            m_pend, m_own_dm, m_we;
  int            m_issue, m_resp, m_starve;
  logic [DW-1:0] m_data, m_wd_last, m_if_rd, m_dm_rd;
  logic [AW-1:0] m_addr_last;
  logic          e_ig, e_dg, e_irv, e_drv, e_busy, e_si, e_sm, e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [7:0]    act_flags, exp_flags;

  typedef struct {
    logic [2:0]  req;
    logic [7:0]  ia;
    logic [7:0]  da;
    logic [31:0] dd;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h cycle=%0d", n, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_starve = 0; m_addr_last = '0; m_wd_last = '0; m_if_rd = '0; m_dm_rd = '0;
  endtask

  task automatic model_eval();
    bit dm_w;
    {e_ig, e_dg, e_irv, e_drv, e_busy, e_en, e_we} = '0;
    e_addr = m_addr_last;
    if (!rst) begin
      model_reset();
      e_addr = '0;
    end else begin
      if (m_pend && cyc == m_resp) begin
        if (m_own_dm) begin
          e_drv = 1'b1;
          if (!m_we) m_dm_rd = m_data;
        end else begin
          e_irv = 1'b1;
          m_if_rd = m_data;
        end
        m_pend = 0;
      end
      e_busy = m_pend && cyc > m_issue;
      if (!m_pend && (if_req || dm_req)) begin
        dm_w = dm_req && (!if_req || m_starve < SMAX);
        e_en = 1'b1; m_pend = 1; m_issue = cyc; m_resp = cyc + LAT + 1;
        if (dm_w) begin
          e_dg = 1'b1; e_we = dm_we; e_addr = dm_addr;
          m_own_dm = 1; m_we = dm_we; m_wd_last = dm_wdata;
          if (dm_we) mmem[dm_addr] = dm_wdata;
          else m_data = mmem[dm_addr];
          if (if_req && m_starve < SMAX) m_starve++;
        end else begin
          e_ig = 1'b1; e_addr = if_addr;
          m_own_dm = 0; m_we = 0; m_data = mmem[if_addr]; m_starve = 0;
        end
        m_addr_last = e_addr;
      end
    end
    e_si = rst & if_req & ~e_irv;
    e_sm = rst & dm_req & ~e_drv;
  endtask

  task automatic step();
    logic          en_s, we_s;
    logic [AW-1:0] a_s;
    logic [DW-1:0] wd_s;
    model_eval();
    @(negedge clk);
    act_flags = {if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, stall_if, mem_en, mem_we};
    exp_flags = {e_ig, e_dg, e_irv, e_drv, e_busy, e_si, e_en, e_we};
    chk("flags{ig,dg,irv,drv,busy,si,en,we}", 32'(act_flags), 32'(exp_flags));
    chk("stall_m", 32'(stall_m), 32'(e_sm));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("if_rdata", if_rdata, m_if_rd);
    chk("dm_rdata", dm_rdata, m_dm_rd);
    if (e_dg && e_we) chk("mem_wdata", mem_wdata, m_wd_last);
    en_s = mem_en; we_s = mem_we; a_s = mem_addr; wd_s = mem_wdata;
    @(posedge clk);
    #1;
    if (en_s && we_s) mem[a_s] = wd_s;
    for (int k = LAT; k >= 2; k--) pipe[k] = pipe[k-1];
    pipe[1] = (en_s && !we_s) ? mem[a_s] : $urandom;
    mem_rdata = pipe[LAT];
    cyc++;
  endtask

  initial begin
    int         rv, lat, n;
    logic [9:0] seq;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
    end
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'hCAFEF00D;
    for (int i = 0; i < 256; i++) mmem[i] = mem[i];
    for (int k = 1; k <= LAT; k++) pipe[k] = $urandom;
    model_reset();

    // reset with random inputs, then idle
    #1;
    for (int i = 0; i < 4; i++) begin
      if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
      if_addr = 8'($urandom); dm_addr = 8'($urandom); dm_wdata = $urandom;
      step();
    end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    rst = 1'b1;
    repeat (3) step();

    // IF read, IF/DM collision, DM store
    vecs.push_back('{3'b100, 8'h10, 8'h00, 32'h0, 8'b1000_0110});
    vecs.push_back('{3'b100, 8'h10, 8'h00, 32'h0, 8'b0000_1100});
    vecs.push_back('{3'b100, 8'h10, 8'h00, 32'h0, 8'b0000_1100});
    vecs.push_back('{3'b000, 8'h10, 8'h00, 32'h0, 8'b0010_0000});
    vecs.push_back('{3'b000, 8'h10, 8'h00, 32'h0, 8'b0000_0000});
    vecs.push_back('{3'b110, 8'h10, 8'h20, 32'h0, 8'b0100_0110});
    vecs.push_back('{3'b110, 8'h10, 8'h20, 32'h0, 8'b0000_1100});
    vecs.push_back('{3'b110, 8'h10, 8'h20, 32'h0, 8'b0000_1100});
    vecs.push_back('{3'b100, 8'h10, 8'h20, 32'h0, 8'b1001_0110});
    vecs.push_back('{3'b100, 8'h10, 8'h20, 32'h0, 8'b0000_1100});
    vecs.push_back('{3'b100, 8'h10, 8'h20, 32'h0, 8'b0000_1100});
    vecs.push_back('{3'b000, 8'h10, 8'h20, 32'h0, 8'b0010_0000});
    vecs.push_back('{3'b000, 8'h10, 8'h20, 32'h0, 8'b0000_0000});
    vecs.push_back('{3'b011, 8'h00, 8'h05, 32'h1234, 8'b0100_0011});
    vecs.push_back('{3'b011, 8'h00, 8'h05, 32'h1234, 8'b0000_1000});
    vecs.push_back('{3'b011, 8'h00, 8'h05, 32'h1234, 8'b0000_1000});
    vecs.push_back('{3'b000, 8'h00, 8'h05, 32'h1234, 8'b0001_0000});
    foreach (vecs[i]) begin
      {if_req, dm_req, dm_we} = vecs[i].req;
      if_addr = vecs[i].ia; dm_addr = vecs[i].da; dm_wdata = vecs[i].dd;
      step();
      chk($sformatf("vec%0d", i), 32'(act_flags), 32'(vecs[i].exp));
      if (vecs[i].exp[0]) chk("vec_store_wdata", mem_wdata, 32'h1234);
    end
    chk("if_rdata_held", if_rdata, 32'hDEADBEEF);
    chk("dm_rdata_after_store", dm_rdata, 32'hCAFEF00D);

    // anti-starvation: both requesters held high
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; if_addr = 8'h10; dm_addr = 8'h20;
    seq = '0; n = 0;
    for (int k = 0; k < 40 && n < 10; k++) begin
      step();
      if (act_flags[7] | act_flags[6]) begin
        seq = {seq[8:0], act_flags[6]};
        n++;
      end
    end
    chk("starve_grant_order", 32'(seq), 32'(10'b1111011110));
    if_req = 1'b0; dm_req = 1'b0;
    repeat (5) step();

    // reset while a read is in flight
    if_req = 1'b1; if_addr = 8'h10;
    step();
    chk("inflight_gnt", 32'(act_flags[7]), 32'd1);
    rst = 1'b0; if_req = 1'b0;
    step();
    rst = 1'b1; rv = 0;
    repeat (5) begin
      step();
      rv += int'(act_flags[5]);
    end
    chk("dropped_rvalid", 32'(rv), 32'd0);
    if_req = 1'b1; if_addr = 8'h20; lat = -1;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      step();
      if (act_flags[5]) lat = k;
    end
    chk("post_reset_latency", 32'(lat), 32'(LAT + 1));
    chk("post_reset_if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0;
    repeat (5) step();

    // randomized legal requesters against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 64) != 0;
      if (!(if_req && !e_ig)) begin
        if_req = ($urandom % 3) != 0;
        if_addr = 8'($urandom % 16);
      end
      if (!(dm_req && !e_dg)) begin
        dm_req = ($urandom % 3) != 0;
        dm_we = 1'($urandom);
        dm_addr = 8'($urandom % 16);
        dm_wdata = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
